// File: rtl/bcd2bin_arbiter_pkg.sv
// Shared types and constants for the round-robin BCD-to-binary converter arbiter.
package bcd2bin_arbiter_pkg;
  localparam int unsigned BCD_MAX = 9;
  localparam int unsigned BIN_W   = 7;
  localparam int unsigned DIG_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  function automatic logic digit_ok(input logic [DIG_W-1:0] d);
    return d <= DIG_W'(BCD_MAX);
  endfunction
endpackage

// File: rtl/bcd2bin_arbiter_if.sv
// Requester and converter signal bundle; slave = arbiter, master = surrounding logic.
interface bcd2bin_arbiter_if #(parameter int unsigned NREQ = 4);
  import bcd2bin_arbiter_pkg::*;

  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] req_bcd;
  logic [NREQ-1:0]   ack;
  logic [BIN_W-1:0]  resp_bin;
  logic              resp_err;
  logic              busy;
  logic              conv_start;
  logic [DIG_W-1:0]  conv_bcd1;
  logic [DIG_W-1:0]  conv_bcd0;
  logic              conv_ready;
  logic              conv_done_tick;
  logic [BIN_W-1:0]  conv_bin;

  modport slave (
    input  req, req_bcd, conv_ready, conv_done_tick, conv_bin,
    output ack, resp_bin, resp_err, busy, conv_start, conv_bcd1, conv_bcd0
  );

  modport master (
    output req, req_bcd, conv_ready, conv_done_tick, conv_bin,
    input  ack, resp_bin, resp_err, busy, conv_start, conv_bcd1, conv_bcd0
  );
endinterface

// File: rtl/bcd2bin_rr_pick.sv
// Combinational round-robin picker: first asserted request after ptr, wrapping.
module bcd2bin_rr_pick #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned PW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   grant,
  output logic            any_req
);
  logic [PW-1:0] idx;

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = PW'((32'(ptr) + k) % NREQ);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = idx;
      end
    end
  end
endmodule

// File: rtl/bcd2bin_arbiter.sv
// Shares one BCD-to-binary converter among NREQ requesters with round-robin grant,
// start/done sequencing, a WAIT watchdog and a one-cycle ack back to the winner.
module bcd2bin_arbiter
  import bcd2bin_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic             clk,
  input  logic             reset_n,
  bcd2bin_arbiter_if.slave bus
);
  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t           state, state_n;
  logic [PW-1:0]    ptr, ptr_n, gnt, gnt_n, pick;
  logic             any_req;
  logic [DIG_W-1:0] bcd1, bcd1_n, bcd0, bcd0_n;
  logic [BIN_W-1:0] res_bin, res_bin_n;
  logic             res_err, res_err_n;
  logic [TW-1:0]    wd, wd_n;
  logic             start;
  logic [7:0]       sel_bcd;
  logic [NREQ-1:0]  ack_vec;

  bcd2bin_rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .grant   (pick),
    .any_req (any_req)
  );

  assign sel_bcd = bus.req_bcd[{pick, 3'b000} +: 8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      ptr     <= PW'(NREQ - 1);
      gnt     <= '0;
      bcd1    <= '0;
      bcd0    <= '0;
      res_bin <= '0;
      res_err <= 1'b0;
      wd      <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      gnt     <= gnt_n;
      bcd1    <= bcd1_n;
      bcd0    <= bcd0_n;
      res_bin <= res_bin_n;
      res_err <= res_err_n;
      wd      <= wd_n;
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    gnt_n     = gnt;
    bcd1_n    = bcd1;
    bcd0_n    = bcd0;
    res_bin_n = res_bin;
    res_err_n = res_err;
    wd_n      = wd;
    start     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (any_req) begin
          gnt_n     = pick;
          bcd1_n    = sel_bcd[7:4];
          bcd0_n    = sel_bcd[3:0];
          res_bin_n = '0;
          if (!digit_ok(sel_bcd[7:4]) || !digit_ok(sel_bcd[3:0])) begin
            res_err_n = 1'b1;
            state_n   = S_RESP;
          end else begin
            res_err_n = 1'b0;
            state_n   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (bus.conv_ready) begin
          start   = 1'b1;
          wd_n    = '0;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        // Done wins over a watchdog expiry landing in the same cycle.
        if (bus.conv_done_tick) begin
          res_bin_n = bus.conv_bin;
          res_err_n = 1'b0;
          state_n   = S_RESP;
        end else if (wd == TW'(TIMEOUT)) begin
          res_bin_n = '0;
          res_err_n = 1'b1;
          state_n   = S_RESP;
        end else begin
          wd_n = wd + TW'(1);
        end
      end
      S_RESP: begin
        ptr_n   = gnt;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    ack_vec = '0;
    if (state == S_RESP) ack_vec[gnt] = 1'b1;
  end

  assign bus.ack        = ack_vec;
  assign bus.resp_bin   = (state == S_RESP) ? res_bin : '0;
  assign bus.resp_err   = (state == S_RESP) ? res_err : 1'b0;
  assign bus.busy       = (state != S_IDLE);
  assign bus.conv_start = start;
  assign bus.conv_bcd1  = bcd1;
  assign bus.conv_bcd0  = bcd0;
endmodule

// File: tb/tb_bcd2bin_arbiter.sv
// Directed bench for bcd2bin_arbiter with a 5-cycle converter model.
module tb_bcd2bin_arbiter;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 31;

  logic clk;
  logic reset_n;
  logic ready_en;
  logic mute;
  logic force_done;
  int   errors = 0;
  int   checks = 0;
  int   n_start = 0;
  int   n_ack = 0;

  bcd2bin_arbiter_if #(.NREQ(NREQ)) bus ();

  bcd2bin_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Converter model: done pulses in the 5th cycle after the start cycle.
  logic [2:0] cnt;
  logic [6:0] lat;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      lat <= '0;
    end else if (bus.conv_start && cnt == 3'd0) begin
      cnt <= 3'd5;
      lat <= 7'(bus.conv_bcd1 * 10 + bus.conv_bcd0);
    end else if (cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end
  assign bus.conv_ready     = ready_en && (cnt == 3'd0);
  assign bus.conv_done_tick = (cnt == 3'd1 && !mute) || force_done;
  assign bus.conv_bin       = lat;

  always @(posedge clk) if (bus.conv_start) n_start <= n_start + 1;
  always @(negedge clk) if (bus.ack != '0) n_ack <= n_ack + 1;

  typedef struct {
    int slot;
    int b1;
    int b0;
    int bin;
    int err;
    int cyc;
  } vec_t;
  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_slot(input int s, input int b1, input int b0);
    bus.req_bcd[s*8 +: 8] = {4'(b1), 4'(b0)};
  endtask

  task automatic wait_ack(output int cyc, output int a, output int b, output int e);
    logic seen;
    seen = 1'b0;
    cyc = 0; a = 0; b = 0; e = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      cyc++;
      if (bus.ack != '0) begin
        seen = 1'b1;
        a = int'(bus.ack);
        b = int'(bus.resp_bin);
        e = int'(bus.resp_err);
      end
    end
    check("ack_arrives", int'(seen), 1);
  endtask

  initial begin
    int cyc, a, b, e, s0, a0;
    int order_bin[4];

    // Latency counts rising edges from the grant edge to the edge that raises ack,
    // i.e. ack lands in the 8th cycle counting the grant cycle as the first.
    vecs[0] = '{slot: 2, b1: 1,  b0: 2,  bin: 12, err: 0, cyc: 7};
    vecs[1] = '{slot: 1, b1: 1,  b0: 10, bin: 0,  err: 1, cyc: 1};
    vecs[2] = '{slot: 0, b1: 10, b0: 0,  bin: 0,  err: 1, cyc: 1};
    vecs[3] = '{slot: 3, b1: 9,  b0: 9,  bin: 99, err: 0, cyc: 7};
    vecs[4] = '{slot: 0, b1: 0,  b0: 0,  bin: 0,  err: 0, cyc: 7};
    order_bin = '{99, 42, 0, 37};

    reset_n = 1'b0; ready_en = 1'b1; mute = 1'b0; force_done = 1'b0;
    bus.req = '0; bus.req_bcd = '0;
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_ack", int'(bus.ack), 0);
    check("rst_bin", int'(bus.resp_bin), 0);
    check("rst_err", int'(bus.resp_err), 0);
    check("rst_bcd", int'({bus.conv_bcd1, bus.conv_bcd0}), 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      set_slot(vecs[i].slot, vecs[i].b1, vecs[i].b0);
      bus.req = '0;
      bus.req[vecs[i].slot] = 1'b1;
      s0 = n_start;
      wait_ack(cyc, a, b, e);
      bus.req = '0;
      check($sformatf("v%0d_ack", i), a, 1 << vecs[i].slot);
      check($sformatf("v%0d_bin", i), b, vecs[i].bin);
      check($sformatf("v%0d_err", i), e, vecs[i].err);
      check($sformatf("v%0d_lat", i), cyc, vecs[i].cyc);
      tick();
      check($sformatf("v%0d_ack_once", i), int'(bus.ack), 0);
      check($sformatf("v%0d_idle", i), int'(bus.busy), 0);
      check($sformatf("v%0d_starts", i), n_start - s0, vecs[i].err ? 0 : 1);
    end

    // All four held: rotation 0,1,2,3,0 starting from slot 0 after reset pointer.
    set_slot(0, 9, 9); set_slot(1, 4, 2); set_slot(2, 0, 0); set_slot(3, 3, 7);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(cyc, a, b, e);
      check($sformatf("rr%0d_ack", k), a, 1 << (k % 4));
      check($sformatf("rr%0d_bin", k), b, order_bin[k % 4]);
      if (k > 0) check($sformatf("rr%0d_gap", k), cyc, 8);
    end
    bus.req = '0;
    tick();

    // Converter silent: watchdog abort, then a late done must be ignored.
    mute = 1'b1;
    set_slot(3, 2, 5);
    bus.req = 4'b1000;
    wait_ack(cyc, a, b, e);
    bus.req = '0;
    check("to_ack", a, 4'b1000);
    check("to_err", e, 1);
    check("to_bin", b, 0);
    check("to_lat", cyc, TIMEOUT + 3);
    mute = 1'b0;
    tick();
    force_done = 1'b1;
    a0 = n_ack;
    tick();
    force_done = 1'b0;
    tick();
    check("late_done_busy", int'(bus.busy), 0);
    check("late_done_noack", n_ack - a0, 0);
    set_slot(0, 5, 0);
    bus.req = 4'b0001;
    wait_ack(cyc, a, b, e);
    bus.req = '0;
    check("post_to_ack", a, 4'b0001);
    check("post_to_bin", b, 50);
    check("post_to_err", e, 0);
    check("post_to_lat", cyc, 7);
    tick();

    // Converter not ready for 3 ISSUE cycles.
    ready_en = 1'b0;
    set_slot(1, 4, 2);
    bus.req = 4'b0010;
    s0 = n_start;
    tick();
    bus.req = '0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("nr%0d_start", k), int'(bus.conv_start), 0);
      check($sformatf("nr%0d_busy", k), int'(bus.busy), 1);
      tick();
    end
    ready_en = 1'b1;
    #1;
    check("nr_start_on_ready", int'(bus.conv_start), 1);
    wait_ack(cyc, a, b, e);
    check("nr_ack", a, 4'b0010);
    check("nr_bin", b, 42);
    check("nr_one_start", n_start - s0, 1);
    tick();

    // Reset during WAIT: no ack, outputs return to reset values.
    set_slot(2, 3, 3);
    bus.req = 4'b0100;
    a0 = n_ack;
    for (int k = 0; k < 4; k++) tick();
    check("mid_busy_before", int'(bus.busy), 1);
    reset_n = 1'b0;
    bus.req = '0;
    #1;
    check("mid_busy", int'(bus.busy), 0);
    check("mid_bcd", int'({bus.conv_bcd1, bus.conv_bcd0}), 0);
    check("mid_bin", int'(bus.resp_bin), 0);
    tick(); tick();
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    check("mid_no_ack", n_ack - a0, 0);
    check("mid_idle", int'(bus.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
